// File: rtl/btn_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_cond_pkg
// Description : Shared definitions for the push-button conditioner: per-channel
//               state encoding and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_cond_pkg;

    // Per-channel state encoding (5 states in 3 bits)
    localparam int unsigned c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] btn_state_t;

    localparam btn_state_t c_ST_RELEASED   = 3'd0;
    localparam btn_state_t c_ST_PRESS_DB   = 3'd1;
    localparam btn_state_t c_ST_PRESSED    = 3'd2;
    localparam btn_state_t c_ST_LONG       = 3'd3;
    localparam btn_state_t c_ST_RELEASE_DB = 3'd4;

    // Width of a counter that must hold every value up to and including max_val
    function automatic int f_cnt_width(input int unsigned max_val);
        f_cnt_width = $clog2(max_val) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_channel
// Description : One button channel: two-flop synchroniser, press/release
//               debounce FSM, hold and auto-repeat counters, registered pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_channel
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned REPEAT_CYCLES   = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int c_DB_W   = f_cnt_width(DEBOUNCE_CYCLES);
    localparam int c_HOLD_W = f_cnt_width(HOLD_CYCLES);
    localparam int c_RPT_W  = f_cnt_width(REPEAT_CYCLES);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES);
    localparam logic [c_RPT_W-1:0]  c_RPT_LAST  = c_RPT_W'(REPEAT_CYCLES);

    // A single stable sample is already enough to accept an edge
    localparam bit c_DB_SINGLE = (DEBOUNCE_CYCLES <= 1);
    // Long-press and repeat are switched off entirely when the hold time is 0
    localparam bit c_HOLD_EN   = (HOLD_CYCLES != 0);

    logic                r_meta;
    logic                r_sync;
    btn_state_t          r_state;
    logic                r_from_long;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_RPT_W-1:0]  r_rpt_cnt;
    logic                r_level;
    logic                r_press;
    logic                r_release;
    logic                r_long;
    logic                r_repeat;

    btn_state_t          w_state_nxt;
    logic                w_from_long_nxt;
    logic [c_DB_W-1:0]   w_db_cnt_nxt;
    logic [c_HOLD_W-1:0] w_hold_cnt_nxt;
    logic [c_RPT_W-1:0]  w_rpt_cnt_nxt;
    logic                w_level_nxt;
    logic                w_press_nxt;
    logic                w_release_nxt;
    logic                w_long_nxt;
    logic                w_repeat_nxt;
    logic [c_DB_W-1:0]   w_db_inc;
    logic [c_HOLD_W-1:0] w_hold_inc;
    logic [c_RPT_W-1:0]  w_rpt_inc;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_btn_raw;
            r_sync <= r_meta;
        end
    end

    // Next-state, counter and output-pulse decode for the debounce FSM
    always_comb begin
        w_state_nxt     = r_state;
        w_from_long_nxt = r_from_long;
        w_db_cnt_nxt    = r_db_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_rpt_cnt_nxt   = r_rpt_cnt;
        w_level_nxt     = r_level;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;
        w_repeat_nxt    = 1'b0;
        w_db_inc        = r_db_cnt + 1'b1;
        w_hold_inc      = r_hold_cnt + 1'b1;
        w_rpt_inc       = r_rpt_cnt + 1'b1;

        case (r_state)
            c_ST_RELEASED: begin
                if (r_sync) begin
                    if (c_DB_SINGLE) begin
                        w_state_nxt    = c_ST_PRESSED;
                        w_level_nxt    = 1'b1;
                        w_press_nxt    = 1'b1;
                        w_hold_cnt_nxt = '0;
                    end else begin
                        w_state_nxt  = c_ST_PRESS_DB;
                        w_db_cnt_nxt = c_DB_W'(1);
                    end
                end
            end

            c_ST_PRESS_DB: begin
                if (!r_sync) begin
                    w_state_nxt = c_ST_RELEASED;
                end else if (w_db_inc == c_DB_LAST) begin
                    w_state_nxt    = c_ST_PRESSED;
                    w_level_nxt    = 1'b1;
                    w_press_nxt    = 1'b1;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_db_cnt_nxt = w_db_inc;
                end
            end

            c_ST_PRESSED, c_ST_LONG: begin
                if (!r_sync) begin
                    // Counters freeze while the release is being qualified
                    w_from_long_nxt = (r_state == c_ST_LONG);
                    if (c_DB_SINGLE) begin
                        w_state_nxt   = c_ST_RELEASED;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = c_ST_RELEASE_DB;
                        w_db_cnt_nxt = c_DB_W'(1);
                    end
                end else if (r_state == c_ST_PRESSED) begin
                    if (c_HOLD_EN) begin
                        w_hold_cnt_nxt = w_hold_inc;
                        if (w_hold_inc == c_HOLD_LAST) begin
                            w_state_nxt   = c_ST_LONG;
                            w_long_nxt    = 1'b1;
                            w_repeat_nxt  = i_repeat_en;
                            w_rpt_cnt_nxt = '0;
                        end
                    end
                end else begin
                    // hold_cnt stays at its terminal value while in LONG
                    if (w_rpt_inc == c_RPT_LAST) begin
                        w_rpt_cnt_nxt = '0;
                        w_repeat_nxt  = i_repeat_en;
                    end else begin
                        w_rpt_cnt_nxt = w_rpt_inc;
                    end
                end
            end

            c_ST_RELEASE_DB: begin
                if (r_sync) begin
                    w_state_nxt = r_from_long ? c_ST_LONG : c_ST_PRESSED;
                end else if (w_db_inc == c_DB_LAST) begin
                    w_state_nxt   = c_ST_RELEASED;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_db_cnt_nxt = w_db_inc;
                end
            end

            default: begin
                w_state_nxt = c_ST_RELEASED;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_RELEASED;
            r_from_long <= 1'b0;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_rpt_cnt   <= '0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_repeat    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_from_long <= w_from_long_nxt;
            r_db_cnt    <= w_db_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_rpt_cnt   <= w_rpt_cnt_nxt;
            r_level     <= w_level_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_long      <= w_long_nxt;
            r_repeat    <= w_repeat_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner
// Description : Multi-channel push-button front end; one independent
//               debounce channel per button.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned REPEAT_CYCLES   = 20000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long,
    output logic [NUM_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_btn_raw   (btn_raw[i]),
            .i_repeat_en (repeat_en[i]),
            .o_level     (btn_level[i]),
            .o_press     (btn_press[i]),
            .o_release   (btn_release[i]),
            .o_long      (btn_long[i]),
            .o_repeat    (btn_repeat[i])
        );
    end

endmodule
`default_nettype wire
